muldiv_hilo_unit: RTL and testbench
===================================

// Module: muldiv_hilo_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers, serving the MIPS core datapath.
//  Executes MULT/MULTU/DIV/DIVU over several cycles and writes the results into HI/LO.
//  Also executes MTHI/MTLO. The core stalls on busy and reads hi/lo for MFHI/MFLO.
//  Parametrised in operand width and in bits retired per cycle.
// PARAMETERS
//  WIDTH           32  operand width; HI and LO are WIDTH bits each
//  BITS_PER_CYCLE  1   product/quotient bits retired per CALC cycle; must divide WIDTH
//                      N = WIDTH/BITS_PER_CYCLE
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      synchronous, active-low reset
//  start     in   1      request; sampled only when busy=0
//  op        in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others: no-op
//  srca      in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//  srcb      in   WIDTH  rt operand (multiplier / divisor)
//  busy      out  1      operation in flight; core stalls on busy
//  done      out  1      1-cycle pulse: hi/lo now hold the new result
//  divzero   out  1      sticky until next accepted start: last DIV/DIVU had srcb==0
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; hi=lo=0; busy=done=divzero=0.
//    Reset mid-operation abandons it; hi/lo still go to 0.
//  - FSM IDLE -> CALC -> SIGN -> IDLE.
//    IDLE + start + mul/div op: latch |srca|, |srcb| and sign info; clear divzero; go to CALC.
//    CALC: N cycles, BITS_PER_CYCLE bits per cycle (shift-add multiply, restoring divide).
//    SIGN: 1 cycle; applies sign correction and writes hi/lo at the end of the cycle.
//  - busy=1 for exactly N+1 cycles after the accepting edge (CALC + SIGN).
//    In the following cycle: busy=0, done=1, hi/lo show the new values.
//  - start while busy=1 is ignored; no queueing.
//    A new start is legal in the same cycle that done=1.
//  - MTHI/MTLO: no busy. At the accepting edge, hi (or lo) <= srca; done=1 the next cycle.
//    Undefined op codes: no state change, no done.
//  - hi/lo hold their old values for the whole time busy=1.
//  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product; signed result = two's-complement negation
//    when the operand signs differ.
//  - DIV/DIVU: lo = quotient, hi = remainder.
//    Signed: quotient sign = sign(a) ^ sign(b); remainder takes the sign of the dividend.
//  - Signed overflow MIN_INT / -1: lo = MIN_INT, hi = 0 (wraps naturally; no flag).
//  - Divide by zero (srcb==0, DIV or DIVU): lo = all ones, hi = srca, divzero=1.
//    Same N+1 latency.
// CONFIGURATION
//  MULDIV_ABORT_EN defined: adds input port abort (1 bit).
//    abort=1 while busy: return to IDLE at that edge; hi/lo/divzero unchanged; no done pulse.
//    abort has no effect in IDLE. If start and abort are both high in IDLE, the start is accepted.
//  MULDIV_ABORT_EN undefined: no abort port; every accepted op runs to completion.
// TESTING (WIDTH=32, BITS_PER_CYCLE=1, so N=32)
//  1. reset=0 for 1 edge -> hi=lo=0, busy=0, done=0, divzero=0.
//  2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then done=1 with
//     hi=0xFFFFFFFE, lo=0x00000001.
//  3. MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     A start issued mid-operation is ignored (result and timing unchanged).
//  4. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//  5. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, divzero=1.
//     MTHI 0x1234 follows in the done cycle -> next cycle hi=0x1234, divzero=0, done=1.
//  6. MULTU 6*7 with reset=0 at CALC cycle 10 -> busy=0, hi=lo=0.
//     With MULDIV_ABORT_EN: abort at cycle 10 -> hi/lo keep prior values, no done pulse.

Source files
------------

// File: rtl/muldiv_hilo_unit_if.sv
// Core <-> multiply/divide unit bus.
// The core drives the request side (master); the unit answers with busy/done/divzero and HI/LO (slave).
// Optional macro MULDIV_ABORT_EN adds an abort request line.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_ABORT_EN
    logic             abort;

    modport master (
        output start, op, srca, srcb, abort,
        input  busy, done, divzero, hi, lo
    );
    modport slave (
        input  start, op, srca, srcb, abort,
        output busy, done, divzero, hi, lo
    );
`else
    modport master (
        output start, op, srca, srcb,
        input  busy, done, divzero, hi, lo
    );
    modport slave (
        input  start, op, srca, srcb,
        output busy, done, divzero, hi, lo
    );
`endif
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division on operand magnitudes.
// These run for N = WIDTH/BITS_PER_CYCLE CALC cycles, followed by one SIGN cycle that
// applies the sign fix-up and writes HI/LO. MTHI/MTLO write HI/LO directly without raising busy.
// BITS_PER_CYCLE must divide WIDTH.
// Optional macro MULDIV_ABORT_EN: abort while busy returns to IDLE, leaving HI/LO/divzero untouched.
module muldiv_hilo_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_hilo_unit_if.slave bus
);
    localparam int                N        = WIDTH / BITS_PER_CYCLE;
    localparam int                CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

    // op[2]==0 selects mul/div; op[1] picks divide; op[0]==0 means signed.
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Request decode
    logic             w_abort;
    logic             w_accept_md;
    logic             w_accept_mt;
    logic             w_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    // Working datapath: acc_hi = partial product / remainder, acc_lo = multiplier / quotient
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_mul;
    logic             r_neg_a;
    logic             r_neg_res;
    logic             r_dz;

    // One CALC cycle worth of iteration
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    // Sign-corrected result
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Architectural state
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_divzero;

`ifdef MULDIV_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept_md = (r_state == S_IDLE) && bus.start && !bus.op[2];
    assign w_accept_mt = (r_state == S_IDLE) && bus.start &&
                         ((bus.op == OP_MTHI) || (bus.op == OP_MTLO));
    assign w_signed    = !bus.op[0];
    assign w_neg_a     = w_signed && bus.srca[WIDTH-1];
    assign w_neg_b     = w_signed && bus.srcb[WIDTH-1];
    assign w_abs_a     = w_neg_a ? -bus.srca : bus.srca;
    assign w_abs_b     = w_neg_b ? -bus.srcb : bus.srcb;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: IDLE -> CALC (N cycles) -> SIGN -> IDLE, abort drops straight to IDLE
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_md) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_SIGN;
                end
            end
            S_SIGN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Iteration step: BITS_PER_CYCLE shift-add or restoring-divide steps chained in one cycle
    always_comb begin
        // NOTE: blocking assignments here build a combinational chain; each loop pass sees the previous pass's result.
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        w_sum     = '0;
        w_shift   = '0;
        w_diff    = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_is_mul) begin
                w_sum     = {1'b0, w_step_hi} + (w_step_lo[0] ? {1'b0, r_b} : '0);
                w_step_lo = {w_sum[0], w_step_lo[WIDTH-1:1]};
                w_step_hi = w_sum[WIDTH:1];
            end else begin
                w_shift = {w_step_hi, w_step_lo[WIDTH-1]};
                w_diff  = w_shift[WIDTH-1:0] - r_b;
                if (w_shift >= {1'b0, r_b}) begin
                    w_step_hi = w_diff;
                    w_step_lo = {w_step_lo[WIDTH-2:0], 1'b1};
                end else begin
                    w_step_hi = w_shift[WIDTH-1:0];
                    w_step_lo = {w_step_lo[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Sign fix-up: negate product, quotient follows sign(a)^sign(b), remainder follows dividend.
    // Divide by zero leaves |a| in acc_hi, so negating it restores the original srca.
    always_comb begin
        w_prod_neg = -{r_acc_hi, r_acc_lo};
        w_res_hi   = r_acc_hi;
        w_res_lo   = r_acc_lo;
        if (r_is_mul) begin
            if (r_neg_res) begin
                {w_res_hi, w_res_lo} = w_prod_neg;
            end
        end else begin
            if (r_neg_a) begin
                w_res_hi = -r_acc_hi;
            end
            if (r_dz) begin
                w_res_lo = '1;
            end else if (r_neg_res) begin
                w_res_lo = -r_acc_lo;
            end
        end
    end

    // Working datapath: load magnitudes on accept, iterate during CALC
    always_ff @(posedge clk) begin
        // NOTE: working registers carry no reset; they are always loaded on accept before being read.
        if (w_accept_md) begin
            r_acc_hi  <= '0;
            r_acc_lo  <= w_abs_a;
            r_b       <= w_abs_b;
            r_cnt     <= '0;
            r_is_mul  <= !bus.op[1];
            r_neg_a   <= w_neg_a;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_dz      <= bus.op[1] && (bus.srcb == '0);
        end else if (r_state == S_CALC) begin
            r_acc_hi  <= w_step_hi;
            r_acc_lo  <= w_step_lo;
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    // Architectural HI/LO, done pulse and sticky divzero
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept_mt) begin
                if (bus.op == OP_MTHI) begin
                    r_hi <= bus.srca;
                end else begin
                    r_lo <= bus.srca;
                end
                r_done    <= 1'b1;
                r_divzero <= 1'b0;
            end else if (w_accept_md) begin
                r_divzero <= 1'b0;
            end else if ((r_state == S_SIGN) && !w_abort) begin
                r_hi      <= w_res_hi;
                r_lo      <= w_res_lo;
                r_done    <= 1'b1;
                r_divzero <= r_dz;
            end
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.divzero = r_divzero;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit (WIDTH=32, BITS_PER_CYCLE=1, N=32).
// Expected HI/LO/divzero are pushed to a scoreboard when an op is driven, popped on done.
// Abort checks are compiled in when MULDIV_ABORT_EN is defined.
module tb_muldiv_hilo_unit;
    localparam int WIDTH = 32;
    localparam int N     = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dz;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    exp_t arch;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_hilo_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_hilo_unit #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model built on the simulator's own arithmetic
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input exp_t cur);
        exp_t               r;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        r  = cur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            OP_MULT:  begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; r.dz = 1'b0; end
            OP_MULTU: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; r.dz = 1'b0; end
            OP_DIV: begin
                if (b == 32'd0) begin
                    r.lo = '1; r.hi = a; r.dz = 1'b1;
                end else begin
                    sq = sa / sb; sr = sa % sb;
                    r.lo = sq[31:0]; r.hi = sr[31:0]; r.dz = 1'b0;
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    r.lo = '1; r.hi = a; r.dz = 1'b1;
                end else begin
                    p = ua / ub; r.lo = p[31:0];
                    p = ua % ub; r.hi = p[31:0]; r.dz = 1'b0;
                end
            end
            OP_MTHI: begin r.hi = a; r.dz = 1'b0; end
            OP_MTLO: begin r.lo = a; r.dz = 1'b0; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic sb_push(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz;
        sb_q.push_back(e);
    endtask

    // Called on a negedge: holds start for one posedge, returns on the following negedge
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb: observed done with empty scoreboard expected pending entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_hi"}, bus.hi, e.hi);
            check({tag, "_lo"}, bus.lo, e.lo);
            check({tag, "_dz"}, bus.divzero, e.dz);
            arch = e;
        end
    endtask

    // Counts busy cycles (bounded), checks HI/LO hold, optionally pokes a start mid-op
    task automatic wait_done(input string tag, input int poke);
        int cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            check({tag, "_hold_hi"}, bus.hi, arch.hi);
            check({tag, "_hold_lo"}, bus.lo, arch.lo);
            if (poke != 0 && cnt == poke) begin
                bus.start = 1'b1; bus.op = OP_MULTU; bus.srca = 32'd1; bus.srcb = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        bus.start = 1'b0;
        check({tag, "_busy_cycles"}, cnt, N + 1);
        check({tag, "_done"}, bus.done, 1'b1);
        pop_compare(tag);
    endtask

    task automatic mt_done(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b1);
        pop_compare(tag);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_hi"}, bus.hi, arch.hi);
        check({tag, "_lo"}, bus.lo, arch.lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.srca  = '0;
        bus.srcb  = '0;
`ifdef MULDIV_ABORT_EN
        bus.abort = 1'b0;
`endif
        arch  = '0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_dz", bus.divzero, 1'b0);
        reset = 1'b1;
        idle_cycle("post_rst");

        // Full-range unsigned product
        sb_push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 0);
        idle_cycle("after_multu");

        // Signed product with a start poked mid-operation (must be ignored)
        sb_push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        drive(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", 10);

        // Back-to-back divides issued in the done cycle
        sb_push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 0);
        sb_push(32'h0000_0000, 32'h8000_0000, 1'b0);
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0);
        idle_cycle("after_div");

        // Divide by zero, then MTHI in the done cycle clears divzero
        sb_push(32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        drive(OP_DIVU, 32'd5, 32'd0);
        wait_done("divu_zero", 0);
        sb_push(32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        drive(OP_MTHI, 32'h0000_1234, 32'd0);
        mt_done("mthi");
        idle_cycle("after_mthi");

        // Signed divide by zero with negative dividend; undefined ops must leave everything alone
        sb_push(32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
        drive(OP_DIV, 32'hFFFF_FFF8, 32'd0);
        wait_done("div_neg_zero", 0);
        drive(3'b110, 32'hDEAD_BEEF, 32'h1);
        check("undef6_done", bus.done, 1'b0);
        check("undef6_busy", bus.busy, 1'b0);
        check("undef6_dz", bus.divzero, 1'b1);
        drive(3'b111, 32'hDEAD_BEEF, 32'h1);
        check("undef7_done", bus.done, 1'b0);
        check("undef7_hi", bus.hi, arch.hi);
        check("undef7_lo", bus.lo, arch.lo);
        sb_push(32'hFFFF_FFF8, 32'h0000_ABCD, 1'b0);
        drive(OP_MTLO, 32'h0000_ABCD, 32'd0);
        mt_done("mtlo");

        // Random mul/div against the model
        for (int i = 0; i < 10; i++) begin
            r_op = 3'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            sb_q.push_back(model(r_op, r_a, r_b, arch));
            drive(r_op, r_a, r_b);
            wait_done("rand", 0);
        end

        // Reset in CALC cycle 10 abandons the op and clears HI/LO
        sb_push(32'h0000_0077, arch.lo, 1'b0);
        drive(OP_MTHI, 32'h0000_0077, 32'd0);
        mt_done("mthi_pre_rst");
        drive(OP_MULTU, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        check("rst_mid_busy_pre", bus.busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        arch = '0;
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_done", bus.done, 1'b0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        check("rst_mid_dz", bus.divzero, 1'b0);
        idle_cycle("after_rst_mid");
        sb_push(32'd0, 32'd5, 1'b0);
        drive(OP_MTLO, 32'd5, 32'd0);
        mt_done("mtlo_post_rst");

`ifdef MULDIV_ABORT_EN
        // Abort in CALC cycle 10 keeps HI/LO and produces no done
        sb_push(32'h0000_0099, 32'd5, 1'b0);
        drive(OP_MTHI, 32'h0000_0099, 32'd0);
        mt_done("mthi_pre_abort");
        drive(OP_MULTU, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_hi", bus.hi, arch.hi);
        check("abort_lo", bus.lo, arch.lo);
        repeat (3) idle_cycle("after_abort");
        // start and abort together in IDLE: start wins
        bus.abort = 1'b1;
        sb_push(32'd0, 32'd6, 1'b0);
        drive(OP_MULTU, 32'd2, 32'd3);
        bus.abort = 1'b0;
        wait_done("abort_idle_start", 0);
`endif

        idle_cycle("final");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
